// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix loader and rotation stage.
// Element k of a packed matrix word lives at [MAT_W-1-k*ELEM_W -: ELEM_W].
package matrix_pkg;
  localparam int N      = 3;
  localparam int ELEM_W = 4;
  localparam int NELEM  = N * N;
  localparam int MAT_W  = NELEM * ELEM_W;
  localparam int K_W    = $clog2(NELEM);

  typedef enum logic {FILL, HOLD} state_t;

  // MSB position of element slot k in the packed matrix word
  function automatic int slot_msb(input logic [K_W-1:0] k);
    return MAT_W - 1 - int'(k) * ELEM_W;
  endfunction
endpackage

// File: rtl/matrix_loader.sv
// Serial-to-parallel loader: nine row-major elements in, one packed 3x3 matrix
// plus rot/dir command out, held until the downstream consumer acknowledges it.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [1:0]          in_rot,
  input  logic                in_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAT_W-1:0]    out_mat,
  output logic [1:0]          out_rot,
  output logic                out_dir,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frame_cnt
);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [MAT_W-1:0]   shadow_q, shadow_nxt;
  logic [1:0]         rot_sh_q;
  logic               dir_sh_q;
  logic               acc, at_end, good, bad, hs;

  // ready is forced low while reset is asserted, not just after it
  assign in_ready = rst_n & (state_q == FILL);

  assign acc    = in_valid & in_ready;
  assign at_end = (k_q == K_W'(NELEM - 1));
  assign good   = acc & in_last & at_end;
  assign bad    = acc & (in_last ^ at_end);
  assign hs     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      FILL: begin
        if (acc) k_d = (good | bad) ? '0 : k_q + 1'b1;
        if (good) state_d = HOLD;
      end
      HOLD: begin
        if (hs) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Shadow including the element being accepted this cycle, so the final
  // element reaches out_mat with single-cycle latency.
  always_comb begin
    shadow_nxt = shadow_q;
    if (acc) shadow_nxt[slot_msb(k_q) -: ELEM_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      rot_sh_q <= '0;
      dir_sh_q <= 1'b0;
    end else if (acc) begin
      shadow_q <= shadow_nxt;
      if (k_q == '0) begin
        rot_sh_q <= in_rot;
        dir_sh_q <= in_dir;
      end
    end
  end

  // Output registers are only ever overwritten by a good frame, so the
  // rotation stage always sees a coherent matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mat   <= '0;
      out_rot   <= '0;
      out_dir   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= bad;
      if (good) begin
        out_valid <= 1'b1;
        out_mat   <= shadow_nxt;
        out_rot   <= (k_q == '0) ? in_rot : rot_sh_q;
        out_dir   <= (k_q == '0) ? in_dir : dir_sh_q;
      end else if (hs) begin
        out_valid <= 1'b0;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: good frames, back-pressure, malformed
// frames, mid-frame reset and a 256-frame counter wrap.
module tb_matrix_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic [1:0]  in_rot;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_mat;
  logic [1:0]  out_rot;
  logic        out_dir;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;

  matrix_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_rot(in_rot), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat),
    .out_rot(out_rot), .out_dir(out_dir), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one element from a negedge and hold it until a posedge accepts it.
  task automatic send_elem(input logic [3:0] d, input logic last,
                           input logic [1:0] rot, input logic dir);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_rot = rot; in_dir = dir;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
  endtask

  // Send nine elements; in_last on element last_pos (9 = never).
  task automatic send_frame(input logic [35:0] vals, input int last_pos,
                            input logic [1:0] rot, input logic dir);
    for (int i = 0; i < 9; i++)
      send_elem(vals[35-4*i -: 4], (i == last_pos), rot, dir);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [35:0] ref_mat;
    logic [35:0] hold_mat;
    logic [3:0]  d;
    logic [1:0]  r;
    logic [7:0]  exp_cnt;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_rot = '0; in_dir = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mat", out_mat, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // 1: basic frame, immediate handshake
    send_frame(36'h123456789, 8, 2'd1, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_mat", out_mat, 36'h123456789);
    chk("t1_rot", out_rot, 1);
    chk("t1_dir", out_dir, 0);
    chk("t1_ready_hold", in_ready, 0);
    chk("t1_err", frame_err, 0);
    @(negedge clk);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_mat_kept", out_mat, 36'h123456789);
    chk("t1_ready_back", in_ready, 1);

    // 2: back-pressure for five cycles
    out_ready = 1'b0;
    send_frame(36'h987654321, 8, 2'd2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("t2_valid_held", out_valid, 1);
      chk("t2_ready_low", in_ready, 0);
      chk("t2_mat_stable", out_mat, 36'h987654321);
      chk("t2_cmd", {out_rot, out_dir}, {2'd2, 1'b1});
      if (c == 4) out_ready = 1'b1;
      @(negedge clk);
    end
    chk("t2_valid_drop", out_valid, 0);
    chk("t2_ready_back", in_ready, 1);
    chk("t2_cnt", frame_cnt, 2);

    // 3: early last on the 4th element, then a clean frame
    for (int i = 0; i < 4; i++)
      send_elem(4'(10 + i), (i == 3), 2'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_err_pulse", frame_err, 1);
    chk("t3_no_valid", out_valid, 0);
    chk("t3_mat_kept", out_mat, 36'h987654321);
    @(negedge clk);
    chk("t3_err_single", frame_err, 0);
    send_frame(36'hABCDEF012, 8, 2'd3, 1'b1);
    chk("t3_valid", out_valid, 1);
    chk("t3_mat", out_mat, 36'hABCDEF012);
    chk("t3_cmd", {out_rot, out_dir}, {2'd3, 1'b1});
    chk("t3_no_err", frame_err, 0);
    @(negedge clk);
    chk("t3_cnt", frame_cnt, 3);

    // 4: missing last on the 9th element
    send_frame(36'h555555555, 9, 2'd1, 1'b0);
    chk("t4_err_pulse", frame_err, 1);
    chk("t4_no_valid", out_valid, 0);
    chk("t4_mat_kept", out_mat, 36'hABCDEF012);
    @(negedge clk);
    chk("t4_err_single", frame_err, 0);
    chk("t4_cnt", frame_cnt, 3);

    // 5: reset after five elements
    for (int i = 0; i < 5; i++)
      send_elem(4'(i + 1), 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_mat_zero", out_mat, 0);
    chk("t5_cmd_zero", {out_rot, out_dir}, 0);
    chk("t5_cnt_zero", frame_cnt, 0);
    chk("t5_ready_low", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(36'h314159265, 8, 2'd0, 1'b1);
    chk("t5_valid", out_valid, 1);
    chk("t5_mat", out_mat, 36'h314159265);
    chk("t5_cmd", {out_rot, out_dir}, {2'd0, 1'b1});
    @(negedge clk);
    chk("t5_cnt", frame_cnt, 1);

    // 6: 256 frames with random gaps; counter wraps back to zero
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int f = 0; f < 256; f++) begin
      ref_mat = '0;
      r = 2'($urandom_range(0, 3));
      for (int i = 0; i < 9; i++) begin
        d = 4'($urandom_range(0, 15));
        ref_mat = {ref_mat[31:0], d};
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
        send_elem(d, (i == 8), r, f[0]);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      hold_mat = out_mat;
      chk("t6_valid", out_valid, 1);
      chk("t6_mat", hold_mat, ref_mat);
      chk("t6_cmd", {out_rot, out_dir}, {r, f[0]});
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      chk("t6_cnt", frame_cnt, exp_cnt);
    end
    chk("t6_wrap", frame_cnt, 0);
    chk("t6_no_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
